// File: rtl/leaf_packet_rx_if.sv
// Purpose: BFT-to-user receive bundle for leaf_packet_rx (packet in, per-port payload streams out).
// Latency: none, wires only.
// Backpressure: per-port ap_vld/ap_ack toward the user. There is no backpressure toward the BFT; credit pulses replace it.
// Signals: din_leaf_bft2interface (packet in), dout_leaf_interface2user / vld_interface2user / ack_user2interface
//          (per-port streams), credit_pulse, drop_count, err_seq (status).
// Modports: master = packet source plus user consumer side; slave = the depacketizer.
interface leaf_packet_rx_if #(
    parameter int PACKET_BITS  = 49,
    parameter int PAYLOAD_BITS = 32,
    parameter int NUM_PORTS    = 2
);
    logic [PACKET_BITS-1:0]            din_leaf_bft2interface;
    logic [NUM_PORTS*PAYLOAD_BITS-1:0] dout_leaf_interface2user;
    logic [NUM_PORTS-1:0]              vld_interface2user;
    logic [NUM_PORTS-1:0]              ack_user2interface;
    logic [NUM_PORTS-1:0]              credit_pulse;
    logic [15:0]                       drop_count;
    logic                              err_seq;

    modport master (
        output din_leaf_bft2interface, ack_user2interface,
        input  dout_leaf_interface2user, vld_interface2user, credit_pulse, drop_count, err_seq
    );

    modport slave (
        input  din_leaf_bft2interface, ack_user2interface,
        output dout_leaf_interface2user, vld_interface2user, credit_pulse, drop_count, err_seq
    );
endinterface

// File: rtl/leaf_packet_rx.sv
// Purpose: leaf depacketizer. It checks the leaf address, strips the header and steers the payload into per-port FIFOs.
// Latency: 2 edges from din to vld (input register, then FIFO write). Pops run at 1 word/cycle per port.
// Backpressure: ap_vld/ap_ack per user port. None toward the BFT: an overflowing FIFO drops the word and counts it.
// Ports: clk_user (sole clock), reset (async, active-low), rx_if (leaf_packet_rx_if.slave).
// Packet fields: [48] valid, [47:43] dest leaf, [42:39] dest port, [38:32] sequence, [31:0] payload.
// Optional: define LEAF_RX_SEQ_CHECK_EN to enable the per-port sequence check that drives err_seq.
module leaf_packet_rx #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_PORTS             = 2,
    parameter int LEAF_ID               = 0,
    parameter int FIFO_DEPTH_BITS       = 3,
    parameter int FREESPACE_UPDATE_SIZE = 4
) (
    input  logic               clk_user,
    input  logic               reset,
    leaf_packet_rx_if.slave    rx_if
);
    localparam int DEPTH    = 1 << FIFO_DEPTH_BITS;
    localparam int PTR_W    = FIFO_DEPTH_BITS + 1;
    localparam int CNT_W    = $clog2(FREESPACE_UPDATE_SIZE + 1);
    localparam int SEQ_LSB  = PAYLOAD_BITS;
    localparam int PORT_LSB = SEQ_LSB + 7;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

    // State
    logic [PACKET_BITS-1:0]                          din_q, din_d;
    logic [NUM_PORTS-1:0][DEPTH-1:0][PAYLOAD_BITS-1:0] mem_q, mem_d;
    logic [NUM_PORTS-1:0][PTR_W-1:0]                 wr_ptr_q, wr_ptr_d;
    logic [NUM_PORTS-1:0][PTR_W-1:0]                 rd_ptr_q, rd_ptr_d;
    logic [NUM_PORTS-1:0][CNT_W-1:0]                 pop_cnt_q, pop_cnt_d;
    logic [NUM_PORTS-1:0]                            credit_q, credit_d;
    logic [15:0]                                     drop_q, drop_d;

    // Decode of the registered packet
    logic                     pkt_vld;
    logic [NUM_LEAF_BITS-1:0] pkt_leaf;
    logic [NUM_PORT_BITS-1:0] pkt_port;
    logic [6:0]               pkt_seq;
    logic [PAYLOAD_BITS-1:0]  pkt_payload;
    logic                     leaf_hit;
    logic                     port_ok;
    logic                     accept;

    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] pop;
    logic [NUM_PORTS-1:0] wr_sel;
    logic [NUM_PORTS-1:0] wr_en;
    logic                 overflow;
    logic                 drop_ev;
    logic [NUM_PORTS*PAYLOAD_BITS-1:0] dout;

    assign pkt_vld     = din_q[PACKET_BITS-1];
    assign pkt_leaf    = din_q[LEAF_LSB +: NUM_LEAF_BITS];
    assign pkt_port    = din_q[PORT_LSB +: NUM_PORT_BITS];
    assign pkt_seq     = din_q[SEQ_LSB +: 7];
    assign pkt_payload = din_q[PAYLOAD_BITS-1:0];

    assign leaf_hit = pkt_vld && (pkt_leaf == NUM_LEAF_BITS'(LEAF_ID));
    assign port_ok  = (pkt_port < NUM_PORT_BITS'(NUM_PORTS));
    assign accept   = leaf_hit && port_ok;

    // FIFO status and write steering. A full FIFO that pops in the same cycle
    // frees the head slot at that edge, so the write can still go in.
    always_comb begin
        empty    = '0;
        full     = '0;
        pop      = '0;
        wr_sel   = '0;
        wr_en    = '0;
        overflow = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            empty[i]  = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]   = (wr_ptr_q[i][PTR_W-1] != rd_ptr_q[i][PTR_W-1]) &&
                        (wr_ptr_q[i][FIFO_DEPTH_BITS-1:0] == rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]);
            pop[i]    = !empty[i] && rx_if.ack_user2interface[i];
            wr_sel[i] = accept && (pkt_port == NUM_PORT_BITS'(i));
            wr_en[i]  = wr_sel[i] && (!full[i] || pop[i]);
            if (wr_sel[i] && full[i] && !pop[i]) begin
                overflow = 1'b1;
            end
        end
    end

    // Next state for the FIFOs and the credit counters
    always_comb begin
        din_d     = rx_if.din_leaf_bft2interface;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pop_cnt_d = pop_cnt_q;
        credit_d  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_en[i]) begin
                mem_d[i][wr_ptr_q[i][FIFO_DEPTH_BITS-1:0]] = pkt_payload;
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                // Pulse one credit for each FREESPACE_UPDATE_SIZE words the user consumes.
                if (pop_cnt_q[i] == CNT_W'(FREESPACE_UPDATE_SIZE - 1)) begin
                    pop_cnt_d[i] = '0;
                    credit_d[i]  = 1'b1;
                end else begin
                    pop_cnt_d[i] = pop_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Drops: valid packets for this leaf with a port number out of range, or writes into a full, non-popping FIFO.
    // Packets for another leaf are not ours and are ignored without counting.
    assign drop_ev = (leaf_hit && !port_ok) || overflow;

    always_comb begin
        drop_d = drop_q;
        if (drop_ev && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            din_q     <= '0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pop_cnt_q <= '0;
            credit_q  <= '0;
            drop_q    <= '0;
        end else begin
            din_q     <= din_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pop_cnt_q <= pop_cnt_d;
            credit_q  <= credit_d;
            drop_q    <= drop_d;
        end
    end

    // Head word is forced to zero while a port is empty, so dout never shows stale data.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!empty[i]) begin
                dout[i*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[i][rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]];
            end
        end
    end

    assign rx_if.dout_leaf_interface2user = dout;
    assign rx_if.vld_interface2user       = ~empty;
    assign rx_if.credit_pulse             = credit_q;
    assign rx_if.drop_count               = drop_q;

`ifdef LEAF_RX_SEQ_CHECK_EN
    logic [NUM_PORTS-1:0][6:0] exp_seq_q, exp_seq_d;
    logic                      err_q, err_d;

    // Every packet steered to a port advances that port's expected sequence, even if the FIFO drops it.
    // The expected value resyncs to received+1, so one gap flags the error only once.
    always_comb begin
        exp_seq_d = exp_seq_q;
        err_d     = err_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_sel[i]) begin
                if (pkt_seq != exp_seq_q[i]) begin
                    err_d = 1'b1;
                end
                exp_seq_d[i] = pkt_seq + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            exp_seq_q <= '0;
            err_q     <= 1'b0;
        end else begin
            exp_seq_q <= exp_seq_d;
            err_q     <= err_d;
        end
    end

    assign rx_if.err_seq = err_q;
`else
    logic unused_seq;
    assign unused_seq    = ^pkt_seq;
    assign rx_if.err_seq = 1'b0;
`endif
endmodule

// File: tb/tb_leaf_packet_rx.sv
module tb_leaf_packet_rx;
    logic clk_user = 1'b0;
    logic rst_n    = 1'b0;
    always #5 clk_user = ~clk_user;

    leaf_packet_rx_if #(.PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_PORTS(2)) bus();

    leaf_packet_rx #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5), .NUM_PORT_BITS(4),
        .NUM_PORTS(2), .LEAF_ID(0), .FIFO_DEPTH_BITS(3), .FREESPACE_UPDATE_SIZE(4)
    ) dut (
        .clk_user (clk_user),
        .reset    (rst_n),
        .rx_if    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    int pops0 = 0, pops1 = 0;
    int credits0 = 0, credits1 = 0;
    logic prev_cr0 = 1'b0, prev_cr1 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [48:0] pkt(input logic [4:0] leaf, input logic [3:0] port,
                                        input logic [6:0] seq, input logic [31:0] pl);
        return {1'b1, leaf, port, seq, pl};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_user);
        #1;
    endtask

    task automatic send(input logic [48:0] p);
        bus.din_leaf_bft2interface = p;
        tick(1);
        bus.din_leaf_bft2interface = '0;
    endtask

    task automatic clear_model();
        pops0 = 0; pops1 = 0; credits0 = 0; credits1 = 0;
        prev_cr0 = 1'b0; prev_cr1 = 1'b0;
    endtask

    // Monitor: credits are checked against the pops already seen, then this cycle's pops are scored.
    always @(negedge clk_user) begin
        if (rst_n) begin
            if (bus.credit_pulse[0]) begin
                check("credit0_width", {31'd0, prev_cr0}, 32'd0);
                check("credit0_align", {31'd0, (pops0 % 4 == 0) && (pops0 > 0)}, 32'd1);
                credits0++;
            end
            if (bus.credit_pulse[1]) begin
                check("credit1_width", {31'd0, prev_cr1}, 32'd0);
                check("credit1_align", {31'd0, (pops1 % 4 == 0) && (pops1 > 0)}, 32'd1);
                credits1++;
            end
            prev_cr0 = bus.credit_pulse[0];
            prev_cr1 = bus.credit_pulse[1];
            if (bus.vld_interface2user[0] && bus.ack_user2interface[0]) begin
                if (exp0.size() == 0) begin
                    check("pop0_unexpected", bus.dout_leaf_interface2user[31:0], 32'hxxxx_xxxx);
                end else begin
                    check("pop0_data", bus.dout_leaf_interface2user[31:0], exp0.pop_front());
                end
                pops0++;
            end
            if (bus.vld_interface2user[1] && bus.ack_user2interface[1]) begin
                if (exp1.size() == 0) begin
                    check("pop1_unexpected", bus.dout_leaf_interface2user[63:32], 32'hxxxx_xxxx);
                end else begin
                    check("pop1_data", bus.dout_leaf_interface2user[63:32], exp1.pop_front());
                end
                pops1++;
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_vld"},    {30'd0, bus.vld_interface2user}, 32'd0);
        check({tag, "_dout0"},  bus.dout_leaf_interface2user[31:0], 32'd0);
        check({tag, "_dout1"},  bus.dout_leaf_interface2user[63:32], 32'd0);
        check({tag, "_credit"}, {30'd0, bus.credit_pulse}, 32'd0);
        check({tag, "_drop"},   {16'd0, bus.drop_count}, 32'd0);
        check({tag, "_err"},    {31'd0, bus.err_seq}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.din_leaf_bft2interface = '0;
        bus.ack_user2interface     = '0;
        repeat (3) @(posedge clk_user);
        @(negedge clk_user);
        check_reset_state("reset");
        @(posedge clk_user); #1;
        rst_n = 1'b1;
        tick(2);

        // Single word, port 0, with ack held. It must not be visible after one edge but must be visible after two.
        bus.ack_user2interface[0] = 1'b1;
        bus.din_leaf_bft2interface = pkt(5'd0, 4'd0, 7'd0, 32'hDEADBEEF);
        exp0.push_back(32'hDEADBEEF);
        @(posedge clk_user); #1;
        bus.din_leaf_bft2interface = '0;
        @(negedge clk_user);
        check("lat_early_vld0", {31'd0, bus.vld_interface2user[0]}, 32'd0);
        @(negedge clk_user);
        check("lat_vld0",  {31'd0, bus.vld_interface2user[0]}, 32'd1);
        check("lat_dout0", bus.dout_leaf_interface2user[31:0], 32'hDEADBEEF);
        check("lat_vld1",  {31'd0, bus.vld_interface2user[1]}, 32'd0);
        @(negedge clk_user);
        check("popped_vld0", {31'd0, bus.vld_interface2user[0]}, 32'd0);
        @(posedge clk_user); #1;
        bus.ack_user2interface[0] = 1'b0;

        // Ten words into port 1 with no ack: eight are kept and two are dropped.
        for (int k = 0; k < 10; k++) begin
            if (k < 8) exp1.push_back(32'hA000_0000 + k);
            send(pkt(5'd0, 4'd1, 7'd0, 32'hA000_0000 + k));
        end
        tick(3);
        check("ovf_vld1",  {31'd0, bus.vld_interface2user[1]}, 32'd1);
        check("ovf_head1", bus.dout_leaf_interface2user[63:32], 32'hA000_0000);
        check("ovf_drop",  {16'd0, bus.drop_count}, 32'd2);
        bus.ack_user2interface[1] = 1'b1;
        tick(8);
        check("drain_rate_vld1", {31'd0, bus.vld_interface2user[1]}, 32'd0);
        bus.ack_user2interface[1] = 1'b0;

        // A packet for a foreign leaf is ignored; a bad port number counts as a drop.
        send(pkt(5'd1, 4'd0, 7'd0, 32'h1111_1111));
        tick(3);
        check("foreign_drop", {16'd0, bus.drop_count}, 32'd2);
        check("foreign_vld",  {30'd0, bus.vld_interface2user}, 32'd0);
        send(pkt(5'd0, 4'd5, 7'd0, 32'h2222_2222));
        tick(3);
        check("badport_drop", {16'd0, bus.drop_count}, 32'd3);
        check("badport_vld",  {30'd0, bus.vld_interface2user}, 32'd0);

        // Fill port 1, then make the write of a new word coincide with a pop.
        for (int k = 0; k < 8; k++) begin
            exp1.push_back(32'hB000_0000 + k);
            send(pkt(5'd0, 4'd1, 7'd0, 32'hB000_0000 + k));
        end
        tick(3);
        check("full_drop_before", {16'd0, bus.drop_count}, 32'd3);
        bus.din_leaf_bft2interface = pkt(5'd0, 4'd1, 7'd0, 32'hC000_0000);
        exp1.push_back(32'hC000_0000);
        tick(1);
        bus.din_leaf_bft2interface = '0;
        bus.ack_user2interface[1] = 1'b1;
        tick(1);
        bus.ack_user2interface[1] = 1'b0;
        tick(2);
        check("fullpop_drop", {16'd0, bus.drop_count}, 32'd3);
        check("fullpop_head", bus.dout_leaf_interface2user[63:32], 32'hB000_0001);
        bus.ack_user2interface[1] = 1'b1;
        tick(7);
        check("fullpop_occ7", {31'd0, bus.vld_interface2user[1]}, 32'd1);
        tick(1);
        check("fullpop_occ8", {31'd0, bus.vld_interface2user[1]}, 32'd0);
        bus.ack_user2interface[1] = 1'b0;

        // Reset asserted between clock edges while port 0 holds data.
        send(pkt(5'd0, 4'd0, 7'd0, 32'h3333_3333));
        send(pkt(5'd0, 4'd0, 7'd0, 32'h4444_4444));
        tick(3);
        check("pre_rst_vld0", {31'd0, bus.vld_interface2user[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        clear_model();
        @(posedge clk_user); #1;
        rst_n = 1'b1;
        tick(2);
        check("post_rst_vld", {30'd0, bus.vld_interface2user}, 32'd0);

        // Eight pops on port 0 must produce exactly two credit pulses.
        for (int k = 0; k < 8; k++) begin
            exp0.push_back(32'hD000_0000 + k);
            send(pkt(5'd0, 4'd0, 7'd0, 32'hD000_0000 + k));
        end
        tick(3);
        check("credit_none_yet", credits0, 32'd0);
        bus.ack_user2interface[0] = 1'b1;
        tick(11);
        bus.ack_user2interface[0] = 1'b0;
        check("credit_pulses0", credits0, 32'd2);
        check("credit_pops0",   pops0, 32'd8);

`ifdef LEAF_RX_SEQ_CHECK_EN
        rst_n = 1'b0;
        #1;
        clear_model();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        bus.ack_user2interface[0] = 1'b1;
        // Sequences 0..125 bring the expected value to 126, then 126, 127, 0 cover the wrap.
        for (int s = 0; s < 129; s++) begin
            exp0.push_back(32'hE000_0000 + s);
            send(pkt(5'd0, 4'd0, 7'(s % 128), 32'hE000_0000 + s));
        end
        tick(3);
        check("seq_wrap_err", {31'd0, bus.err_seq}, 32'd0);
        exp0.push_back(32'hE000_FFFF);
        send(pkt(5'd0, 4'd0, 7'd5, 32'hE000_FFFF));
        tick(1);
        check("seq_gap_err", {31'd0, bus.err_seq}, 32'd1);
        tick(4);
        check("seq_err_held", {31'd0, bus.err_seq}, 32'd1);
        send(pkt(5'd0, 4'd1, 7'd9, 32'hE111_0000));
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("seq_rst");
        exp1.delete();
        clear_model();
        bus.ack_user2interface[0] = 1'b0;
        @(posedge clk_user); #1;
        rst_n = 1'b1;
        tick(1);
`else
        bus.ack_user2interface[0] = 1'b1;
        exp0.push_back(32'hE000_0005);
        send(pkt(5'd0, 4'd0, 7'd5, 32'hE000_0005));
        tick(3);
        check("seq_ignored_err", {31'd0, bus.err_seq}, 32'd0);
        bus.ack_user2interface[0] = 1'b0;
`endif

        tick(2);
        check("sb_empty0", exp0.size(), 32'd0);
        check("sb_empty1", exp1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/leaf_packet_rx.md
Name: leaf_packet_rx

Overview:
- Receive-side depacketizer for a leaf.
- Accepts 49-bit BFT packets addressed to this leaf, strips the header and steers the 32-bit payload into one of NUM_PORTS per-port FIFOs.
- Presents each FIFO to a user operator input as an ap_vld/ap_ack stream.
- Counts the user pops on each port and emits a freespace credit pulse after every FREESPACE_UPDATE_SIZE pops, so the sender can replenish credit.

Parameters:
- PACKET_BITS, 49, packet width. Bit fields: [48] valid, [47:43] dest leaf, [42:39] dest port, [38:32] sequence, [31:0] payload.
- PAYLOAD_BITS, 32, payload width.
- NUM_LEAF_BITS, 5, width of the dest leaf field.
- NUM_PORT_BITS, 4, width of the dest port field.
- NUM_PORTS, 2, number of user output streams (1..15).
- LEAF_ID, 0, this leaf's address.
- FIFO_DEPTH_BITS, 3, log2 of the depth of each per-port FIFO.
- FREESPACE_UPDATE_SIZE, 4, number of pops per credit pulse (must be at least 1).

Ports:
- clk_user, input, 1, sole clock.
- reset, input, 1, asynchronous, active-low.
- din_leaf_bft2interface, input, PACKET_BITS, incoming packet; qualified by bit [48].
- dout_leaf_interface2user, output, NUM_PORTS*PAYLOAD_BITS, per-port payload; port i occupies bits [32i+31:32i].
- vld_interface2user, output, NUM_PORTS, per-port data valid.
- ack_user2interface, input, NUM_PORTS, per-port consumer accept.
- credit_pulse, output, NUM_PORTS, one-cycle pulse per port each time FREESPACE_UPDATE_SIZE words are popped.
- drop_count, output, 16, saturating count of packets dropped.
- err_seq, output, 1, sticky sequence-error flag; driven only when LEAF_RX_SEQ_CHECK_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFOs empty; all vld_interface2user=0 and dout=0.
  - credit_pulse=0, drop_count=0, err_seq=0, pop counters=0.
  - Reset asserted mid-stream discards all buffered data.
  - Outputs leave reset state on the first clk_user edge after reset rises.
- Input stage:
  - din is registered once.
  - The registered packet is accepted when valid=1, dest leaf=LEAF_ID and dest port<NUM_PORTS.
  - Valid packets with a foreign leaf are ignored silently; they are not counted as drops.
  - Valid packets with port>=NUM_PORTS increment drop_count.
- Write: an accepted packet writes its payload into FIFO[port] in the cycle after registration.
  - If that FIFO is full and not popping in the same cycle: the payload is discarded and drop_count increments; it saturates at 16'hFFFF.
  - Full with a simultaneous pop: the write succeeds and occupancy is unchanged.
- Latency: a packet at din on edge N is visible at vld/dout after edge N+2 when its FIFO was empty (registered input plus FIFO write).
- Output handshake, per port:
  - vld=1 while the FIFO is non-empty; dout shows the head word.
  - A pop occurs when vld&ack are both 1 at a clock edge.
  - ack while vld=0 has no effect.
  - vld and dout are stable until popped.
  - Back-to-back pops sustain 1 word/cycle.
- Pointers are FIFO_DEPTH_BITS+1 wide; full/empty are derived from MSB comparison. Wrap-around is transparent.
- Credit: the per-port pop counter counts 0..FREESPACE_UPDATE_SIZE-1.
  - On the pop that reaches the terminal value, credit_pulse[i]=1 for exactly one cycle (registered, the cycle after the pop) and the counter returns to 0.
- Ports are fully independent; simultaneous pops on all ports are allowed.
- No flow control toward the BFT: sizing is the sender's responsibility via credits, and drops indicate credit violation.

Optional Feature:
- Macro LEAF_RX_SEQ_CHECK_EN.
- Defined:
  - Each port keeps a 7-bit expected sequence, reset to 0.
  - Every accepted packet on the port compares its sequence field with the expected value.
  - On a mismatch, err_seq sets and stays set until reset.
  - In all cases the expected value becomes received+1 mod 128; wrap 127->0 is legal.
  - A dropped (FIFO-full) packet still advances the expected value.
- Undefined: the sequence field is ignored and err_seq is tied to 0.

Test Plan:
- Reset, then leaf=LEAF_ID, port 0, payload 32'hDEADBEEF, with ack[0]=1 -> vld[0]=1 with dout0=DEADBEEF two edges after input, popped next edge; vld[1] stays 0.
- Ten packets to port 1 with ack[1]=0, depth 8 -> vld[1] held with first word; drop_count=2; then ack[1]=1 -> eight words drain in order, one per cycle.
- Packets with leaf=LEAF_ID+1 and with port=5 -> foreign leaf ignored with drop_count unchanged; port 5 gives drop_count+1; no vld.
- Eight pops on port 0 with FREESPACE_UPDATE_SIZE=4 -> exactly two one-cycle credit_pulse[0] pulses, one after the 4th pop and one after the 8th.
- FIFO full at the same edge as a pop plus a new packet -> no drop; occupancy stays 8; order preserved.
- With LEAF_RX_SEQ_CHECK_EN: port 0 sequences 126,127,0 from an expected 126 -> err_seq=0. Then sequence 5 where 1 is expected -> err_seq=1, held; reset low mid-stream clears err_seq, vld and drop_count asynchronously.
